// File: rtl/sram_responder.sv
// sram_responder
//    Stands in for the SLC-3 off-chip SRAM. After reset it sweeps every word
//    to zero (busy high), then answers active-low CE/OE/WE/UB/LB bus cycles
//    on a bidirectional Data bus with one cycle of read latency. A
//    valid/ready side port preloads whole words when the bus is not writing.
//
//    Clk        in     system clock, rising edge
//    Reset      in     asynchronous active-high reset
//    CE/OE/WE   in     chip/output/write enables, active low
//    UB/LB      in     upper/lower byte enables, active low
//    ADDR       in     word address, aliased modulo DEPTH
//    Data       inout  16-bit data bus
//    load_valid in     preload request
//    load_ready out    preload accepted when high with load_valid
//    load_addr  in     preload word address, aliased modulo DEPTH
//    load_data  in     preload word
//    busy       out    high during the clear sweep
module sram_responder #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        CE,
   input  logic        OE,
   input  logic        WE,
   input  logic        UB,
   input  logic        LB,
   input  logic [19:0] ADDR,
   inout  logic [15:0] Data,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [19:0] load_addr,
   input  logic [15:0] load_data,
   output logic        busy
);

   typedef enum logic {CLEAR, SERVE} state_t;

   state_t         state, state_nxt;
   logic [AW-1:0]  clr_cnt;
   logic [15:0]    mem [DEPTH];
   logic [15:0]    rd_reg;
   logic           drive_hi, drive_lo;
   logic           bus_wr, bus_rd, load_fire;
   logic [AW-1:0]  idx, load_idx;
   logic           unused_addr_hi;

   assign idx            = ADDR[AW-1:0];
   assign load_idx       = load_addr[AW-1:0];
   assign unused_addr_hi = ^{ADDR[19:AW], load_addr[19:AW]};

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      load_ready = 1'b0;
      bus_wr     = 1'b0;
      bus_rd     = 1'b0;
      load_fire  = 1'b0;
      case (state)
         CLEAR: begin
            busy = 1'b1;
            if (clr_cnt == '1) state_nxt = SERVE;
         end
         SERVE: begin
            // WE low wins over OE low: such a cycle is a write only
            bus_wr     = ~CE & ~WE;
            bus_rd     = ~CE & WE & ~OE;
            load_ready = ~bus_wr;
            load_fire  = load_valid & load_ready;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         rd_reg   <= '0;
         drive_hi <= 1'b0;
         drive_lo <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         drive_hi <= bus_rd & ~UB;
         drive_lo <= bus_rd & ~LB;
         // nonblocking read returns the pre-edge word even if a preload
         // targets the same index at this edge
         if (bus_rd) rd_reg <= mem[idx];
      end
   end

   always_ff @(posedge Clk) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (bus_wr) begin
         if (!UB) mem[idx][15:8] <= Data[15:8];
         if (!LB) mem[idx][7:0]  <= Data[7:0];
      end else if (load_fire) begin
         mem[load_idx] <= load_data;
      end
   end

   assign Data[15:8] = drive_hi ? rd_reg[15:8] : 8'hzz;
   assign Data[7:0]  = drive_lo ? rd_reg[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//    Directed and randomized bus/preload cycles against a word-array model.
//    Data carries a pull-up, so an undriven byte reads as 8'hFF.
module tb_sram_responder;

   localparam int unsigned DEPTH = 256;

   logic        Clk, Reset;
   logic        CE, OE, WE, UB, LB;
   logic [19:0] ADDR;
   wire  logic [15:0] Data;
   logic        load_valid, load_ready, busy;
   logic [19:0] load_addr;
   logic [15:0] load_data;

   logic        tb_drv;
   logic [15:0] tb_wdata;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_word;
   logic        m_hi, m_lo;
   int          m_clear_left;

   sram_responder #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
      .ADDR(ADDR), .Data(Data), .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .busy(busy)
   );

   assign Data = tb_drv ? tb_wdata : 16'hzzzz;
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (Data[i]);
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_view();
      return {m_hi ? m_word[15:8] : 8'hFF, m_lo ? m_word[7:0] : 8'hFF};
   endfunction

   // one clock of bus activity; starts and ends 2 time units after an edge
   task automatic cycle(input logic ce, input logic oe, input logic we,
                        input logic ub, input logic lb, input logic [19:0] addr,
                        input logic [15:0] wdata, input logic lv,
                        input logic [19:0] laddr, input logic [15:0] ldata);
      logic wr, rd;
      int   i;
      wr = !ce && !we;
      rd = !ce && we && !oe;
      CE = ce; OE = oe; WE = we; UB = ub; LB = lb; ADDR = addr;
      load_valid = lv; load_addr = laddr; load_data = ldata;
      tb_drv = wr; tb_wdata = wdata;
      #1;
      chk("load_ready", {15'd0, load_ready}, {15'd0, (m_clear_left == 0) && !wr});
      @(posedge Clk);
      if (m_clear_left > 0) begin
         m_clear_left--;
         m_hi = 1'b0; m_lo = 1'b0;
      end else begin
         i = int'(addr % DEPTH);
         if (rd) begin
            m_word = m_mem[i]; m_hi = !ub; m_lo = !lb;
         end else begin
            m_hi = 1'b0; m_lo = 1'b0;
         end
         if (wr) begin
            if (!ub) m_mem[i] = {wdata[15:8], m_mem[i][7:0]};
            if (!lb) m_mem[i] = {m_mem[i][15:8], wdata[7:0]};
         end else if (lv) begin
            m_mem[int'(laddr % DEPTH)] = ldata;
         end
      end
      #1;
      tb_drv = 1'b0;
      #1;
      chk("data", Data, m_view());
      chk("busy", {15'd0, busy}, {15'd0, m_clear_left != 0});
   endtask

   task automatic idle();
      cycle(1, 1, 1, 1, 1, 20'h0, 16'h0, 0, 20'h0, 16'h0);
   endtask

   task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
      cycle(0, 1, 0, ub, lb, a, d, 0, 20'h0, 16'h0);
   endtask

   task automatic rd(input logic [19:0] a, input logic ub, input logic lb);
      cycle(0, 0, 1, ub, lb, a, 16'h0, 0, 20'h0, 16'h0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      CE = 1; OE = 1; WE = 1; UB = 1; LB = 1; ADDR = '0;
      load_valid = 0; load_addr = '0; load_data = '0; tb_drv = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
      m_hi = 0; m_lo = 0; m_word = '0; m_clear_left = DEPTH;
      #1;
      chk("rst_busy", {15'd0, busy}, 16'd1);
      chk("rst_ready", {15'd0, load_ready}, 16'd0);
      chk("rst_data", Data, 16'hFFFF);
      repeat (2) @(posedge Clk);
      #2;
      Reset = 1'b0;
   endtask

   // strobes and preloads in the first cycles must be ignored by the sweep
   task automatic wait_clear(input string tag);
      int fall_at;
      bit done;
      fall_at = 0;
      done = 0;
      for (int n = 1; n <= DEPTH + 8 && !done; n++) begin
         if (n <= 4) cycle(0, 1, 0, 0, 0, 20'h00003, 16'h5555, 1, 20'h00004, 16'hBEEF);
         else idle();
         if (!busy) begin
            fall_at = n;
            done = 1;
         end
      end
      chk(tag, 16'(fall_at), 16'(DEPTH));
   endtask

   initial begin
      Reset = 0; tb_drv = 0; tb_wdata = '0;
      do_reset();
      wait_clear("clear_len");
      rd(20'h000FF, 0, 0);
      chk("clear_ff", Data, 16'h0000);
      rd(20'h00003, 0, 0);
      chk("clear_ign_wr", Data, 16'h0000);
      rd(20'h00004, 0, 0);
      chk("clear_ign_ld", Data, 16'h0000);
      idle();

      // full-word write then read, OE release
      wr(20'h00031, 16'hA0A0, 0, 0);
      rd(20'h00031, 0, 0);
      chk("rd_full", Data, 16'hA0A0);
      cycle(0, 1, 1, 0, 0, 20'h00031, 16'h0, 0, 20'h0, 16'h0);
      chk("oe_release", Data, 16'hFFFF);

      // byte enables
      wr(20'h00014, 16'hFFFF, 0, 0);
      wr(20'h00014, 16'h1234, 1, 0);
      rd(20'h00014, 0, 0);
      chk("rd_byte", Data, 16'hFF34);
      rd(20'h00014, 0, 1);
      chk("rd_lb_off", Data, 16'hFFFF);
      idle();
      wr(20'h00014, 16'h5A00, 0, 1);
      rd(20'h00014, 0, 1);
      chk("rd_lb_off2", Data, 16'h5AFF);
      rd(20'h00014, 0, 0);
      chk("rd_hi_wr", Data, 16'h5A34);
      idle();

      // preload blocked by a bus write to an aliasing address
      CE = 0; WE = 0; OE = 1; UB = 0; LB = 0; ADDR = 20'h0015A;
      load_valid = 1; #1;
      chk("ld_blocked", {15'd0, load_ready}, 16'd0);
      cycle(0, 1, 0, 0, 0, 20'h0015A, 16'hEEEE, 1, 20'h0005A, 16'h0002);
      cycle(1, 1, 1, 1, 1, 20'h0, 16'h0, 1, 20'h0005A, 16'h0002);
      rd(20'h0005A, 0, 0);
      chk("ld_prio", Data, 16'h0002);
      rd(20'h0015A, 0, 0);
      chk("ld_alias", Data, 16'h0002);
      idle();

      // WE and OE both low is a write without drive
      cycle(0, 0, 0, 0, 0, 20'h00006, 16'h1111, 0, 20'h0, 16'h0);
      chk("weoe_nodrv", Data, 16'hFFFF);
      rd(20'h00006, 0, 0);
      chk("weoe_rd", Data, 16'h1111);

      // read and preload at the same index: old word first
      cycle(0, 0, 1, 0, 0, 20'h00031, 16'h0, 1, 20'h00006, 16'h7777);
      chk("rd_vs_ld_other", Data, 16'hA0A0);
      cycle(0, 0, 1, 0, 0, 20'h00006, 16'h0, 1, 20'h00006, 16'h7777);
      chk("rd_vs_ld_old", Data, 16'h7777);
      cycle(0, 0, 1, 0, 0, 20'h00020, 16'h0, 1, 20'h00020, 16'h3C3C);
      chk("rd_vs_ld_same", Data, 16'h0000);
      rd(20'h00020, 0, 0);
      chk("rd_vs_ld_new", Data, 16'h3C3C);
      idle();

      // randomized traffic over a few aliased indices
      for (int n = 0; n < 300; n++) begin
         logic ce, oe, we, ub, lb, lv;
         logic [19:0] a, la;
         int kind;
         kind = int'($urandom_range(0, 3));
         ce = (kind == 0); oe = 1; we = 1;
         if (kind == 1) oe = 0;
         else if (kind == 2) we = 0;
         else if (kind == 3) begin oe = 1'($urandom); we = 1'($urandom); end
         ub = 1'($urandom); lb = 1'($urandom);
         a  = {12'($urandom), 8'($urandom_range(0, 7))};
         la = {12'($urandom), 8'($urandom_range(0, 7))};
         lv = 1'($urandom);
         // the bus master never writes while the responder still drives
         if (!ce && !we && (m_hi || m_lo)) ce = 1;
         cycle(ce, oe, we, ub, lb, a, 16'($urandom), lv, la, 16'($urandom));
      end
      idle();

      // reset in the middle of a driven read
      rd(20'h00031, 0, 0);
      chk("pre_rst_rd", Data, 16'hA0A0);
      do_reset();
      wait_clear("clear_len2");
      rd(20'h00031, 0, 0);
      chk("post_rst_rd", Data, 16'h0000);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the SLC-3 off-chip SRAM bus. It answers the active-low CE/OE/WE/UB/LB strobes, the 20-bit ADDR and the 16-bit bidirectional Data bus that the SLC-3 memory interface drives, and exposes a valid/ready side port for preloading programs. It sits at the top level in place of the physical SRAM, so the week-2 program tests can run end-to-end in simulation and on FPGA without the board memory.

## Interface
- DEPTH, 256: number of implemented 16-bit words; power of two, ≥ 4.
- AW, log2(DEPTH): index width derived from DEPTH; not overridden by users.

- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- CE  in  1  chip enable, active low.
- OE  in  1  output enable, active low.
- WE  in  1  write enable, active low.
- UB  in  1  upper-byte enable (Data[15:8]), active low.
- LB  in  1  lower-byte enable (Data[7:0]), active low.
- ADDR  in  20  word address.
- Data  inout  16  bidirectional data bus.
- load_valid  in  1  preload request.
- load_ready  out  1  preload accepted this cycle when high together with load_valid.
- load_addr  in  20  preload word address.
- load_data  in  16  preload word.
- busy  out  1  high while the clear sweep runs.

## Operation
- Index = ADDR[AW-1:0]. Higher address bits are ignored, so addresses alias modulo DEPTH. The same rule applies to load_addr.
- The state machine has two states, CLEAR and SERVE.
- CLEAR is entered on reset.
  - A counter writes 16'h0000 to indices 0..DEPTH-1, one word per cycle.
  - busy=1 and load_ready=0.
  - All bus strobes are ignored and Data is Z.
  - After the write to index DEPTH-1, the machine goes to SERVE.
- SERVE, bus write:
  - Condition: CE=0 and WE=0, sampled at the edge.
  - Data[15:8] is stored if UB=0. Data[7:0] is stored if LB=0. A byte whose enable is high keeps its old value.
- SERVE, bus read:
  - Condition: CE=0, WE=1, OE=0, sampled at the edge.
  - mem[index] is captured into a read register.
  - Per-byte drive flags are set from UB/LB.
- WE=0 with OE=0 counts as a write. There is no drive and no read capture.
- On any edge without a read condition, the drive flags clear.
- The Data upper byte is driven from the read register while drive_hi=1, otherwise Z. The lower byte works the same way with drive_lo.
- Preload (SERVE only):
  - load_ready = ~busy & ~(CE=0 & WE=0), combinational.
  - When load_valid & load_ready at an edge, the full 16-bit load_data is written to mem[load_addr index].
  - A bus write has priority. A blocked preload is held by the source until accepted, and load_valid must stay asserted until then.
- A preload and a bus read to the same index in the same cycle: the read returns the old word.

## Timing
- Reset values:
  - busy=1, load_ready=0, Data=Z.
  - Drive flags and read register are 0.
  - CLEAR counter is 0.
  - These take effect immediately on Reset assertion, independent of Clk.
- Clear duration: busy falls after exactly DEPTH rising edges following Reset deassertion. The first bus access is honoured at edge DEPTH+1.
- Read latency: Data is valid one cycle after the edge sampling the read condition, and stays until the next edge without a read condition.
- Back-to-back reads with changing ADDR return one word per cycle, pipelined by one cycle.
- Read-after-write: a write at edge n followed by a read at edge n+1 to the same index drives the new value after edge n+1.
- Reset mid-access or mid-CLEAR: Data goes Z asynchronously and CLEAR restarts at index 0. Memory contents before the restart are irrelevant because they are overwritten.
- A strobe change between edges has no effect except on the sampled value at the next edge. Data drive never changes between edges except on Reset.

## Test plan
- **Clear sweep.** Pulse Reset for 2 cycles, then hold strobes inactive. busy stays 1 for exactly 256 cycles, then falls. A read of ADDR=20'h000FF returns 16'h0000.
- **Full-word write/read.**
  - Write 16'hA0A0 to 20'h00031 with UB=LB=0, then read it back. Data=16'hA0A0 one cycle after the read edge.
  - Deasserting OE returns Data to Z one cycle later.
- **Byte enables.**
  - Write 16'hFFFF to 20'h00014. Then write 16'h1234 with UB=1, LB=0. The read gives 16'hFF34.
  - A read with LB=1 drives Data[7:0]=Z and Data[15:8]=8'hFF.
- **Preload vs. bus priority and aliasing.**
  - Hold load_valid with load_addr=20'h0005A and load_data=16'h0002. Issue a bus write to 20'h0015A (aliases to index 0x5A) with 16'hEEEE at the same time.
  - load_ready is 0 during that cycle and the preload is accepted the next cycle. The final read of 20'h0005A gives 16'h0002.
- **WE/OE conflict.** CE=0, OE=0, WE=0 with Data driven to 16'h1111 at 20'h00006. Data is never driven by the block. A following read gives 16'h1111.
- **Reset mid-read.**
  - Assert Reset while Data is driving 16'hA0A0. Data goes Z in the same timestep and busy=1.
  - After release, the old address reads 16'h0000 once busy falls.
